// File: rtl/sram_rw_ctrl.sv
// Front-end for a single-port mask-write SRAM: zero-fill sweep, write/read
// arbitration onto the one port, and a 2-entry read response buffer.
module sram_rw_ctrl #(
    parameter int DATA_W = 76,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [DATA_W-1:0] wreq_data,
    input  logic [DATA_W-1:0] wreq_mask,
    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,
    output logic              rresp_valid,
    input  logic              rresp_ready,
    output logic [DATA_W-1:0] rresp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        RST_WAIT,
        INIT,
        RUN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_init_done;
    logic                r_last_rd;
    logic                r_inflight;
    logic                r_v0;
    logic                r_v1;
    logic [DATA_W-1:0]   r_d0;
    logic [DATA_W-1:0]   r_d1;

    logic                w_run;
    logic                w_pop;
    logic [1:0]          w_outst;
    logic                w_credit;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_conflict;
    logic                w_gnt_w;
    logic                w_gnt_r;
    logic                w_v0_n;
    logic                w_v1_n;
    logic [DATA_W-1:0]   w_d0_n;
    logic [DATA_W-1:0]   w_d1_n;

    assign w_run   = (r_state == RUN);
    assign w_pop   = r_v0 && rresp_ready;
    // Reads in flight plus buffered responses, less the one leaving now.
    assign w_outst = 2'(r_inflight) + 2'(r_v0) + 2'(r_v1);
    assign w_credit = (w_outst - 2'(w_pop)) < 2'd2;

    assign w_rd_ok    = w_run && rreq_valid && w_credit;
    assign w_wr_ok    = w_run && wreq_valid;
    assign w_conflict = w_wr_ok && w_rd_ok;
    assign w_gnt_w    = w_wr_ok && (!w_rd_ok || r_last_rd);
    assign w_gnt_r    = w_rd_ok && (!w_wr_ok || !r_last_rd);

    assign wreq_ready  = w_gnt_w;
    assign rreq_ready  = w_gnt_r;
    assign init_done   = r_init_done;
    assign rresp_valid = r_v0;
    assign rresp_data  = r_d0;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        unique case (r_state)
            INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = r_cnt;
                sram_wmask = '1;
            end
            RUN: begin
                if (w_gnt_w) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = wreq_addr;
                    sram_wmask = wreq_mask;
                    sram_wdata = wreq_data;
                end else if (w_gnt_r) begin
                    sram_en   = 1'b1;
                    sram_addr = rreq_addr;
                end
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

    // Shift-style FIFO: head is always in r_d0 so rresp_data is a plain flop.
    always_comb begin
        w_v0_n = w_pop ? r_v1 : r_v0;
        w_d0_n = w_pop ? r_d1 : r_d0;
        w_v1_n = w_pop ? 1'b0 : r_v1;
        w_d1_n = r_d1;
        if (r_inflight) begin
            if (!w_v0_n) begin
                w_v0_n = 1'b1;
                w_d0_n = sram_rdata;
            end else begin
                w_v1_n = 1'b1;
                w_d1_n = sram_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RST_WAIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_last_rd   <= 1'b1;
            r_inflight  <= 1'b0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_d0        <= '0;
            r_d1        <= '0;
        end else begin
            unique case (r_state)
                RST_WAIT: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                end
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
            if (w_conflict) begin
                r_last_rd <= w_gnt_r;
            end
            r_inflight <= w_gnt_r;
            r_v0       <= w_v0_n;
            r_v1       <= w_v1_n;
            r_d0       <= w_d0_n;
            r_d1       <= w_d1_n;
        end
    end

endmodule

// File: doc/sram_rw_ctrl.md
# sram_rw_ctrl

Front-end controller for one single-port 128x76 SRAM macro with mask-write and a 1-cycle read port. Drives the macro's shared address/enable/write-mode/mask/data pins from the requester side. Accepts independent write and read request channels with valid/ready handshakes, arbitrates them onto the one port, and returns read data through a 2-entry response buffer with backpressure. After reset it zero-fills the whole array before accepting any traffic.

## Interface
- DATA_W, 76: data and mask width
- ADDR_W, 7: address width
- DEPTH, 128: entries swept during init; equals 2^ADDR_W
- clock  in  1  sole clock; every register is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the zero-fill sweep completes
- wreq_valid / wreq_ready  in / out  1 / 1  write request handshake
- wreq_addr  in  ADDR_W  write address
- wreq_data  in  DATA_W  write data
- wreq_mask  in  DATA_W  per-bit write mask; 1 = bit written
- rreq_valid / rreq_ready  in / out  1 / 1  read request handshake
- rreq_addr  in  ADDR_W  read address
- rresp_valid / rresp_ready  out / in  1 / 1  read response handshake
- rresp_data  out  DATA_W  read data, in request order
- sram_en  out  1  macro enable
- sram_wmode  out  1  macro write mode; 1 = write, 0 = read
- sram_addr  out  ADDR_W  macro address
- sram_wmask  out  DATA_W  macro write mask
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data; valid the cycle after a read enable

## Operation
- States: RST_WAIT, INIT, RUN. The async reset places the block in RST_WAIT with the sweep counter at 0.
- RST_WAIT: all sram_* outputs are 0 and both request readies are 0. Moves to INIT on the first rising edge after reset_n goes high.
- INIT: each cycle drives sram_en=1, sram_wmode=1, sram_addr=counter, sram_wmask=all-ones, sram_wdata=0, then increments the counter. After the write to address DEPTH-1, moves to RUN. No request is accepted during INIT.
- RUN: at most one operation is issued per cycle. sram_* outputs are combinational from the granted request.
  - Grant write: sram_en=1, sram_wmode=1; addr, mask and data come from wreq_*.
  - Grant read: sram_en=1, sram_wmode=0, sram_addr=rreq_addr; sram_wmask and sram_wdata are 0.
  - No grant: all sram_* outputs are 0.
- Read credit: `inflight + count - pop < 2`.
  - inflight: a read was issued in the previous cycle.
  - count: number of occupied response-buffer entries (0..2).
  - pop: rresp_valid && rresp_ready.
  - This creates a combinational path from rresp_ready to rreq_ready; that path is required.
- Arbitration when a write is valid and a read is valid with credit: the request type not granted last time wins. A last-grant flag records this; it resets to "read", so the first conflict grants the write. If the read has no credit, the write wins and the flag is left unchanged. A single valid request with its conditions met is granted.
- wreq_ready = RUN && write granted. rreq_ready = RUN && read granted. Both may depend combinationally on the valids; a request must not wait for ready before asserting valid.
- Response buffer: 2-entry FIFO. sram_rdata is pushed at the end of the cycle after a read was issued. rresp_data = head entry. A push and a pop in the same cycle are legal when the buffer is full. Credit accounting guarantees the buffer never overflows; an overflow is an assertion failure in the bench.
- Hazards: the port is single and issue is in order. A read issued the cycle after a write to the same address returns the new data. No forwarding logic.
- Reset mid-operation: the in-flight read is dropped, the buffer is cleared, rresp_valid goes 0 immediately, the last-grant flag resets, and the sweep restarts from address 0.

## Timing
- Reset values: init_done=0, rresp_valid=0, rresp_data=0, wreq_ready=0, rreq_ready=0, all sram_* = 0.
- Init: INIT writes occupy cycles 1..DEPTH after reset release. init_done rises in cycle DEPTH+1 (the first RUN cycle) and stays high until the next reset.
- Write latency: the macro write occurs at the end of the accept cycle.
- Read latency: read accepted in cycle T; macro data in T+1; rresp_valid in T+2. Back-to-back reads with rresp_ready held at 1 sustain 1 response per cycle.
- Outputs rresp_valid, rresp_data and init_done are registered. wreq_ready, rreq_ready and sram_* are combinational.

## Test plan
- Init sweep: release reset, model the macro as 128x76.
  - Expect 128 consecutive zero writes to addresses 0..127, with no other operations.
  - init_done rises in cycle 129.
  - Reading address 5 then returns 0.
- Write/read: write addr 3, data 0x1234, full mask.
  - Read addr 3 in the next cycle; expect rresp_data=0x1234 two cycles after read accept.
- Masked write: addr 7 holds all-ones.
  - Write data 0 with mask 0xFF.
  - Readback is all-ones with bits [7:0] cleared.
- Arbitration: hold wreq_valid and rreq_valid high for 6 cycles with rresp_ready=1.
  - Grants alternate W, R, W, R, W, R.
  - 3 responses arrive in order.
- Backpressure: rresp_ready=0 with rreq_valid held high.
  - Exactly 2 reads are accepted, then rreq_ready stays 0.
  - Raise rresp_ready; reads resume in the same cycle, and responses come out in FIFO order with no loss.
- Reset mid-read: assert reset_n=0 in the cycle after a read accept.
  - rresp_valid and sram_en drop to 0 immediately.
  - After release, the sweep restarts at address 0 and no stale response appears.
